mem_stage_lsu: RTL and testbench

Memory-stage load/store unit for the RV32I pipeline. It consumes the Execute→Memory pipeline signals and drives a request/grant/response data-memory bus. Byte/half/word stores are formatted; load data is aligned and sign- or zero-extended. It stalls the pipeline through Ready while a bus access is outstanding, then registers the Memory→Writeback pipeline values.

---
 rtl/mem_stage_lsu.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory-stage load/store unit with req/gnt/rvalid data bus
//
// Purpose: formats stores, issues data-memory accesses, aligns and extends load
// data, stalls the pipeline through Ready while an access is outstanding, and
// registers the Memory->Writeback pipeline values.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   ALUResultM .. PCPlus4M      Execute->Memory pipeline inputs (held while Ready=0)
//   dmem_req/we/addr/be/wdata   data-memory request channel
//   dmem_gnt                    request accepted
//   dmem_rvalid/rdata           read response
//   Ready                       0 = stall F/D/E/M
//   ExcM                        one-cycle cause: 01 misaligned, 10 timeout, 11 bad funct3
//   *W                          Memory->Writeback pipeline registers
module mem_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        Ready,
  output logic [1:0]  ExcM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RD_W,
  output logic        RegWriteW,
  output logic        ResultSrcW
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]       state, stepState, nextState;
  logic [CNT_W-1:0] cnt;
  logic             access, isStore, isLoad;
  logic             badF3, misaligned, faultIdle, issue;
  logic             complete, timeoutHit, done, readyInt;
  logic [1:0]       offs;
  logic [7:0]       byteSel;
  logic [15:0]      halfSel;
  logic [31:0]      loadData;

  assign offs    = ALUResultM[1:0];
  assign access  = MemReadM | MemWriteM;
  assign isStore = MemWriteM;
  assign isLoad  = MemReadM & ~MemWriteM;

  assign badF3 = isStore ? (funct3_M[2] | (funct3_M == 3'b011))
                         : (isLoad & ((funct3_M == 3'b011) | (funct3_M == 3'b110) |
                                      (funct3_M == 3'b111)));
  assign misaligned = ((funct3_M[1:0] == 2'b01) & offs[0]) |
                      ((funct3_M[1:0] == 2'b10) & (offs != 2'b00));

  // Faults are only evaluated before a request goes out, i.e. in IDLE.
  assign faultIdle = (state == IDLE) & access & (badF3 | misaligned);
  assign issue     = (state == IDLE) & access & ~(badF3 | misaligned);

  always_comb begin
    stepState = state;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          if (dmem_gnt && isStore) complete  = 1'b1;
          else if (dmem_gnt)       stepState = WAIT;
          else                     stepState = REQ;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (isStore) begin
            complete  = 1'b1;
            stepState = IDLE;
          end else begin
            stepState = WAIT;
          end
        end
      end
      WAIT: begin
        // rvalid is only looked at here, so a response coinciding with gnt is dropped.
        if (dmem_rvalid) begin
          complete  = 1'b1;
          stepState = IDLE;
        end
      end
      default: stepState = IDLE;
    endcase
  end

  // cnt counts cycles since issue, so the access is abandoned in its TIMEOUT-th cycle.
  assign timeoutHit = (state != IDLE) & (cnt == CNT_W'(TIMEOUT - 1)) & ~complete;
  assign nextState  = timeoutHit ? IDLE : stepState;
  assign done       = complete | faultIdle | timeoutHit;
  assign readyInt   = ~access | done;
  assign Ready      = rst | readyInt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= (nextState == IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Held M inputs would otherwise re-raise the request while rst is asserted.
  assign dmem_req  = ~rst & (issue | (state == REQ));
  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALUResultM[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (isStore) begin
      case (funct3_M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << offs;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << {offs[1], 1'b0};
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    case (offs)
      2'b00:   byteSel = dmem_rdata[7:0];
      2'b01:   byteSel = dmem_rdata[15:8];
      2'b10:   byteSel = dmem_rdata[23:16];
      default: byteSel = dmem_rdata[31:24];
    endcase
    halfSel = offs[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_M)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = dmem_rdata;
    endcase
  end

  always_comb begin
    ExcM = 2'b00;
    if (!rst) begin
      if (faultIdle)       ExcM = badF3 ? 2'b11 : 2'b01;
      else if (timeoutHit) ExcM = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadDataW  <= '0;
      ALUResultW <= '0;
      PCPlus4W   <= '0;
      RD_W       <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
    end else if (readyInt) begin
      ReadDataW  <= loadData;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      RD_W       <= RD_M;
      RegWriteW  <= RegWriteM & ~faultIdle & ~timeoutHit;
      ResultSrcW <= ResultSrcM;
    end else begin
      RegWriteW  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;
  logic        RegWriteM, MemReadM, MemWriteM, ResultSrcM;
  logic [2:0]  funct3_M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        Ready;
  logic [1:0]  ExcM;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RD_W;
  logic        RegWriteW, ResultSrcW;

  int errors = 0;
  int checks = 0;
  int stalls;
  logic [1:0] excEnd;
  logic       reqSeen;

  mem_stage_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RD_M(RD_M),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3_M(funct3_M), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .Ready(Ready), .ExcM(ExcM),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W),
    .RD_W(RD_W), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setM(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw, input logic rs,
                      input logic [2:0] f3, input logic [31:0] pc);
    ALUResultM = alu; WriteDataM = wd; RD_M = rd; RegWriteM = rw;
    MemReadM = mr; MemWriteM = mw; ResultSrcM = rs; funct3_M = f3; PCPlus4M = pc;
  endtask

  // Drives gnt/rvalid on the given cycle indices (-1 = never) and counts
  // Ready-low cycles until the completion cycle; bounded at 40 cycles.
  task automatic runAccess(input int gntAt, input int rvAt, input logic [31:0] rdata,
                           output int nStall, output logic [1:0] exc);
    logic fin;
    fin = 1'b0;
    nStall = 0;
    exc = 2'b00;
    for (int c = 0; c < 40 && !fin; c++) begin
      dmem_gnt    = (c == gntAt);
      dmem_rvalid = (c == rvAt);
      dmem_rdata  = rdata;
      @(negedge clk);
      if (Ready) begin
        fin = 1'b1;
        exc = ExcM;
      end else begin
        nStall++;
      end
      tick();
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    setM(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    #2;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_ready", {31'd0, Ready}, 32'd1);
    chk("rst_exc", {30'd0, ExcM}, 32'd0);
    chk("rst_aluW", ALUResultW, 32'd0);
    chk("rst_rwW", {31'd0, RegWriteW}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Non-memory instruction
    setM(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h104);
    @(negedge clk);
    chk("nm_req", {31'd0, dmem_req}, 32'd0);
    chk("nm_ready", {31'd0, Ready}, 32'd1);
    tick();
    chk("nm_aluW", ALUResultW, 32'h1234);
    chk("nm_rdW", {27'd0, RD_W}, 32'd5);
    chk("nm_rwW", {31'd0, RegWriteW}, 32'd1);
    chk("nm_pcW", PCPlus4W, 32'h104);

    // SB at 0x1003, granted the same cycle
    setM(32'h1003, 32'hAABBCCDD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h108);
    dmem_gnt = 1'b1;
    @(negedge clk);
    chk("sb_req", {31'd0, dmem_req}, 32'd1);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_be", {28'd0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
    chk("sb_addr", dmem_addr, 32'h1000);
    chk("sb_ready", {31'd0, Ready}, 32'd1);
    tick();
    dmem_gnt = 1'b0;

    // LB at 0x2001: gnt on cycle 2, rvalid on cycle 5
    setM(32'h2001, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'h10C);
    #1;
    chk("lb_be", {28'd0, dmem_be}, 32'hF);
    chk("lb_addr", dmem_addr, 32'h2000);
    runAccess(2, 5, 32'h00008000, stalls, excEnd);
    chk("lb_stalls", stalls, 32'd5);
    chk("lb_data", ReadDataW, 32'hFFFFFF80);
    chk("lb_rwW", {31'd0, RegWriteW}, 32'd1);
    chk("lb_rdW", {27'd0, RD_W}, 32'd7);
    chk("lb_rsW", {31'd0, ResultSrcW}, 32'd1);

    // LBU same address
    setM(32'h2001, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 32'h110);
    runAccess(2, 5, 32'h00008000, stalls, excEnd);
    chk("lbu_stalls", stalls, 32'd5);
    chk("lbu_data", ReadDataW, 32'h00000080);

    // LH at 0x2002, fastest completion (gnt cycle 0, rvalid cycle 1)
    setM(32'h2002, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h114);
    runAccess(0, 1, 32'h80010000, stalls, excEnd);
    chk("lh_stalls", stalls, 32'd1);
    chk("lh_data", ReadDataW, 32'hFFFF8001);

    // SH at 0x4002, gnt on cycle 1
    setM(32'h4002, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h118);
    #1;
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    runAccess(1, -1, 32'h0, stalls, excEnd);
    chk("sh_stalls", stalls, 32'd1);

    // Misaligned LW
    setM(32'h3002, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h11C);
    @(negedge clk);
    chk("mis_exc", {30'd0, ExcM}, 32'd1);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_ready", {31'd0, Ready}, 32'd1);
    tick();
    chk("mis_rwW", {31'd0, RegWriteW}, 32'd0);
    setM(32'h77, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h120);
    #1;
    chk("mis_pulse", {30'd0, ExcM}, 32'd0);
    tick();

    // Bad funct3 load
    setM(32'h3000, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 32'h124);
    @(negedge clk);
    chk("bf3_exc", {30'd0, ExcM}, 32'd3);
    chk("bf3_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("bf3_rwW", {31'd0, RegWriteW}, 32'd0);

    // Timeout: gnt but no rvalid
    setM(32'h5000, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h128);
    runAccess(0, -1, 32'h0, stalls, excEnd);
    chk("to_stalls", stalls, 32'd15);
    chk("to_exc", {30'd0, excEnd}, 32'd2);
    chk("to_rwW", {31'd0, RegWriteW}, 32'd0);
    setM(32'h77, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h12C);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    chk("late_ready", {31'd0, Ready}, 32'd1);
    chk("late_exc", {30'd0, ExcM}, 32'd0);
    chk("late_req", {31'd0, dmem_req}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    chk("late_aluW", ALUResultW, 32'h77);

    // Reset while in WAIT
    setM(32'h6000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h130);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    chk("wait_ready", {31'd0, Ready}, 32'd0);
    chk("wait_req", {31'd0, dmem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mrst_req", {31'd0, dmem_req}, 32'd0);
    chk("mrst_ready", {31'd0, Ready}, 32'd1);
    chk("mrst_aluW", ALUResultW, 32'd0);
    chk("mrst_pcW", PCPlus4W, 32'd0);
    chk("mrst_rdW", {27'd0, RD_W}, 32'd0);
    chk("mrst_rsW", {31'd0, ResultSrcW}, 32'd0);
    setM(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    tick();
    rst = 1'b0;

    // Next access after reset proceeds normally
    setM(32'h6004, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h134);
    runAccess(1, 3, 32'hCAFEBABE, stalls, excEnd);
    chk("post_stalls", stalls, 32'd3);
    chk("post_data", ReadDataW, 32'hCAFEBABE);
    chk("post_rwW", {31'd0, RegWriteW}, 32'd1);
    chk("post_exc", {30'd0, excEnd}, 32'd0);

    // No bus activity for a following non-memory instruction
    setM(32'h55, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h138);
    reqSeen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reqSeen = reqSeen | dmem_req;
      tick();
    end
    chk("nm2_req", {31'd0, reqSeen}, 32'd0);
    chk("nm2_aluW", ALUResultW, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
